fifo_ctrl_arb: RTL and testbench
================================

FIFO_CTRL_ARB -- requirements
Module: fifo_ctrl_arb

Interface
REQ-001 Parameters SHALL be: FIFO_depth, default 16, number of FIFO entries; FIFO_width, default 8, data width; FIFO_cntr_w, default 5, occupancy counter width (must hold 0..FIFO_depth).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 FIFO_reset  input  1  reset, synchronous and active-high.
REQ-004 wr_req0 / wr_req1  input  1 each  write requests from requester 0 / 1.
REQ-005 wr_data0 / wr_data1  input  FIFO_width each  write data from requester 0 / 1.
REQ-006 wr_gnt0 / wr_gnt1  output  1 each  write granted this cycle; data is consumed at the next clk edge.
REQ-007 rd_req  input  1  consumer requests one entry.
REQ-008 rd_ack  output  1  pop issued this cycle; consumer samples FIFO data_out in this cycle.
REQ-009 flush_req / clear_req  input  1 each  request pointer flush / full memory clear.
REQ-010 fifo_data_in  output  FIFO_width; fifo_push, fifo_pop  output  1 each  to FIFO data_in/push/pop.
REQ-011 fifo_reset_n, fifo_clr_n  output  1 each  to FIFO reset/clear, active-low.
REQ-012 count  output  FIFO_cntr_w  occupancy; full, empty  output  1 each; busy  output  1  controller not in RUN.

Function
REQ-013 FSM SHALL have states INIT, RUN, FLUSH, CLEAR; outputs are combinational from state, registered pointer and count.
REQ-014 INIT: fifo_clr_n=0, no grants/pops, busy=1; next state RUN.
REQ-015 RUN: fifo_clr_n=1, fifo_reset_n=1, busy=0; clear_req -> CLEAR, else flush_req -> FLUSH, else stay; clear_req has priority over flush_req.
REQ-016 FLUSH: fifo_reset_n=0 for exactly one cycle, no grants/pops, busy=1, count->0; next RUN.
REQ-017 CLEAR: fifo_clr_n=0 for exactly one cycle, no grants/pops, busy=1, count->0; next RUN.
REQ-018 In the RUN cycle where flush_req or clear_req is sampled, grants and pops SHALL still be issued normally; count updates from that cycle are overridden by the transition to 0.
REQ-019 Write arbitration SHALL be round-robin with a 1-bit priority pointer prio (0 = requester 0 preferred); at most one grant per cycle.
REQ-020 A grant SHALL be issued in RUN only if (count < FIFO_depth) or fifo_pop is asserted the same cycle.
REQ-021 If only one requester is active, it is granted and prio is unchanged; if both are active, the prio requester is granted and prio toggles.
REQ-022 fifo_push = wr_gnt0 | wr_gnt1; fifo_data_in = wr_data1 when wr_gnt1, else wr_data0.
REQ-023 fifo_pop = rd_ack = RUN & rd_req & (count != 0); pops never depend on grants, so there is no combinational loop.
REQ-024 count next value SHALL be: +1 on push only; -1 on pop only; unchanged on push+pop or neither.
REQ-025 empty = (count == 0); full = (count == FIFO_depth).
REQ-026 When full, a write SHALL be granted only in a cycle with a simultaneous pop; count stays FIFO_depth.
REQ-027 When empty, rd_req SHALL be ignored (no pop) even if a push occurs in the same cycle.
REQ-028 Denied requests SHALL NOT be queued; the requester holds wr_req until granted.

Reset
REQ-029 With FIFO_reset=1 at a clk edge: state=INIT, count=0, prio=0.
REQ-030 Outputs during/after reset SHALL be: wr_gnt0/1=0, rd_ack=0, fifo_push=0, fifo_pop=0, fifo_reset_n=1, fifo_clr_n=0 (INIT), busy=1, empty=1, full=0.
REQ-031 Reset asserted mid-operation SHALL override every FSM transition and in-flight count update; the first cycle after release is INIT.

Verification
REQ-032 Reset release -> one INIT cycle with fifo_clr_n=0, then RUN, busy=0, empty=1, count=0.
REQ-033 Both wr_req held for 4 cycles, prio=0 -> grants in order 0,1,0,1; fifo_data_in follows the granted requester; count=4.
REQ-034 Fill to 16 (full=1), then wr_req0 with no rd_req -> wr_gnt0=0; then add rd_req -> wr_gnt0=1, rd_ack=1, count stays 16.
REQ-035 Empty FIFO, wr_req1 + rd_req in the same cycle -> wr_gnt1=1, rd_ack=0, count=1; next cycle rd_ack=1 and data equals wr_data1.
REQ-036 count=5, flush_req and clear_req in the same cycle -> next state CLEAR with fifo_clr_n=0 for one cycle, then RUN with count=0.
REQ-037 FIFO_reset pulsed while in FLUSH with count=3 -> INIT next cycle, count=0, prio=0, no push/pop issued.

Source files
------------

// File: rtl/fifo_ctrl_arb.sv
// FIFO controller: two-requester round-robin write arbiter, read handshake,
// occupancy tracking and FIFO flush/clear sequencing.
module fifo_ctrl_arb #(
   parameter int unsigned FIFO_depth  = 16,
   parameter int unsigned FIFO_width  = 8,
   parameter int unsigned FIFO_cntr_w = 5
) (
   input  logic                   clk,
   input  logic                   FIFO_reset,
   input  logic                   wr_req0,
   input  logic                   wr_req1,
   input  logic [FIFO_width-1:0]  wr_data0,
   input  logic [FIFO_width-1:0]  wr_data1,
   output logic                   wr_gnt0,
   output logic                   wr_gnt1,
   input  logic                   rd_req,
   output logic                   rd_ack,
   input  logic                   flush_req,
   input  logic                   clear_req,
   output logic [FIFO_width-1:0]  fifo_data_in,
   output logic                   fifo_push,
   output logic                   fifo_pop,
   output logic                   fifo_reset_n,
   output logic                   fifo_clr_n,
   output logic [FIFO_cntr_w-1:0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   busy
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   localparam logic [FIFO_cntr_w-1:0] DEPTH_CNT = FIFO_cntr_w'(FIFO_depth);

   state_t                 state_q, state_d;
   logic [FIFO_cntr_w-1:0] count_q, count_d;
   logic                   prio_q, prio_d;

   logic run;
   logic pop_en;
   logic arb_en;
   logic both_req;

   // Handshake outputs decoded from state, count and priority pointer.
   // Pops never look at grants, so grant-through-pop has no loop.
   always_comb begin
      run      = (state_q == ST_RUN);
      pop_en   = run & rd_req & (count_q != '0);
      arb_en   = run & ((count_q < DEPTH_CNT) | pop_en);
      both_req = wr_req0 & wr_req1;

      wr_gnt0      = arb_en & wr_req0 & (~wr_req1 | ~prio_q);
      wr_gnt1      = arb_en & wr_req1 & (~wr_req0 |  prio_q);
      fifo_push    = wr_gnt0 | wr_gnt1;
      fifo_data_in = wr_gnt1 ? wr_data1 : wr_data0;
      fifo_pop     = pop_en;
      rd_ack       = pop_en;

      fifo_reset_n = (state_q != ST_FLUSH);
      fifo_clr_n   = ~((state_q == ST_INIT) | (state_q == ST_CLEAR));
      busy         = ~run;
      count        = count_q;
      empty        = (count_q == '0);
      full         = (count_q == DEPTH_CNT);
   end

   // Next state, occupancy and arbitration pointer.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      prio_d  = prio_q;
      unique case (state_q)
         ST_INIT: state_d = ST_RUN;
         ST_RUN: begin
            if (arb_en & both_req) prio_d = ~prio_q;
            if (fifo_push & ~pop_en)      count_d = count_q + FIFO_cntr_w'(1);
            else if (pop_en & ~fifo_push) count_d = count_q - FIFO_cntr_w'(1);
            if (clear_req)      state_d = ST_CLEAR;
            else if (flush_req) state_d = ST_FLUSH;
         end
         ST_FLUSH, ST_CLEAR: begin
            count_d = '0;
            state_d = ST_RUN;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // State register; synchronous reset overrides every pending update.
   always_ff @(posedge clk) begin
      if (FIFO_reset) begin
         state_q <= ST_INIT;
         count_q <= '0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         prio_q  <= prio_d;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl_arb.sv
// Bench for fifo_ctrl_arb: queue-based reference model checked every cycle,
// plus directed scenarios pinned with literal expectations.
module tb_fifo_ctrl_arb;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned W     = 8;
   localparam int unsigned CW    = 5;

   logic          clk = 1'b0;
   logic          FIFO_reset = 1'b1;
   logic          wr_req0 = 1'b0, wr_req1 = 1'b0;
   logic [W-1:0]  wr_data0 = '0, wr_data1 = '0;
   logic          wr_gnt0, wr_gnt1;
   logic          rd_req = 1'b0;
   logic          rd_ack;
   logic          flush_req = 1'b0, clear_req = 1'b0;
   logic [W-1:0]  fifo_data_in;
   logic          fifo_push, fifo_pop, fifo_reset_n, fifo_clr_n;
   logic [CW-1:0] count;
   logic          full, empty, busy;

   int checks = 0;
   int errors = 0;

   fifo_ctrl_arb #(.FIFO_depth(DEPTH), .FIFO_width(W), .FIFO_cntr_w(CW)) dut (
      .clk(clk), .FIFO_reset(FIFO_reset),
      .wr_req0(wr_req0), .wr_req1(wr_req1),
      .wr_data0(wr_data0), .wr_data1(wr_data1),
      .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1),
      .rd_req(rd_req), .rd_ack(rd_ack),
      .flush_req(flush_req), .clear_req(clear_req),
      .fifo_data_in(fifo_data_in), .fifo_push(fifo_push), .fifo_pop(fifo_pop),
      .fifo_reset_n(fifo_reset_n), .fifo_clr_n(fifo_clr_n),
      .count(count), .full(full), .empty(empty), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO contents as a queue, mode as one of four phases.
   localparam int M_INIT = 0, M_RUN = 1, M_FLUSH = 2, M_CLEAR = 3;
   int           m_mode  = M_INIT;
   bit           m_valid = 0;
   bit           m_prio  = 0;
   logic [W-1:0] m_q[$];
   logic [W-1:0] m_last_pop = '0;

   // Per-cycle compare at the falling edge, then advance the model with the
   // inputs the next rising edge will sample.
   always @(negedge clk) begin
      bit in_run, do_pop, room, any, winner, granted;
      in_run  = (m_mode == M_RUN);
      do_pop  = in_run && rd_req && (m_q.size() > 0);
      room    = (m_q.size() < DEPTH) || do_pop;
      any     = wr_req0 || wr_req1;
      winner  = (wr_req0 && wr_req1) ? m_prio : wr_req1;
      granted = in_run && room && any;
      if (m_valid) begin
         chk("gnt0",  int'(wr_gnt0),   int'(granted && !winner));
         chk("gnt1",  int'(wr_gnt1),   int'(granted && winner));
         chk("push",  int'(fifo_push), int'(granted));
         chk("pop",   int'(fifo_pop),  int'(do_pop));
         chk("rdack", int'(rd_ack),    int'(do_pop));
         chk("count", int'(count),     m_q.size());
         chk("empty", int'(empty),     int'(m_q.size() == 0));
         chk("full",  int'(full),      int'(m_q.size() == DEPTH));
         chk("busy",  int'(busy),      int'(!in_run));
         chk("rst_n", int'(fifo_reset_n), int'(m_mode != M_FLUSH));
         chk("clr_n", int'(fifo_clr_n),   int'(m_mode == M_RUN || m_mode == M_FLUSH));
         if (granted) chk("data_in", int'(fifo_data_in), int'(winner ? wr_data1 : wr_data0));
      end
      if (FIFO_reset) begin
         m_valid = 1;
         m_mode  = M_INIT;
         m_prio  = 0;
         m_q.delete();
      end else if (m_valid) begin
         case (m_mode)
            M_INIT: m_mode = M_RUN;
            M_RUN: begin
               if (do_pop) m_last_pop = m_q.pop_front();
               if (granted) m_q.push_back(winner ? wr_data1 : wr_data0);
               if (granted && wr_req0 && wr_req1) m_prio = !m_prio;
               if (clear_req)      m_mode = M_CLEAR;
               else if (flush_req) m_mode = M_FLUSH;
            end
            default: begin
               m_q.delete();
               m_mode = M_RUN;
            end
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pin(input string name, input int act, input int exp);
      chk(name, act, exp);
   endtask

   initial begin
      // Reset and release
      tick(); tick();
      FIFO_reset = 1'b0;
      @(negedge clk);
      pin("init_clr_n", int'(fifo_clr_n), 0);
      pin("init_busy",  int'(busy), 1);
      pin("init_rst_n", int'(fifo_reset_n), 1);
      tick();
      @(negedge clk);
      pin("run_busy",  int'(busy), 0);
      pin("run_empty", int'(empty), 1);
      pin("run_count", int'(count), 0);
      tick();

      // Both requesters contend: alternating grants
      wr_req0 = 1; wr_req1 = 1; wr_data0 = 8'hA0; wr_data1 = 8'hB1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pin("rr_gnt0", int'(wr_gnt0), (i % 2 == 0) ? 1 : 0);
         pin("rr_data", int'(fifo_data_in), (i % 2 == 0) ? 8'hA0 : 8'hB1);
         tick();
      end
      wr_req1 = 0;
      @(negedge clk);
      pin("rr_count", int'(count), 4);

      // Fill to full, then write only alongside a pop
      for (int i = 0; i < 12; i++) tick();
      @(negedge clk);
      pin("full_flag",   int'(full), 1);
      pin("full_count",  int'(count), 16);
      pin("full_nognt",  int'(wr_gnt0), 0);
      tick();
      rd_req = 1;
      @(negedge clk);
      pin("full_gnt",   int'(wr_gnt0), 1);
      pin("full_rdack", int'(rd_ack), 1);
      tick();
      wr_req0 = 0;
      @(negedge clk);
      pin("full_hold", int'(count), 16);
      for (int i = 0; i < 16; i++) tick();
      @(negedge clk);
      pin("drain_empty", int'(empty), 1);
      pin("drain_noack", int'(rd_ack), 0);
      tick();

      // Empty FIFO: push and read in the same cycle
      wr_req1 = 1; wr_data1 = 8'h5C;
      @(negedge clk);
      pin("e_gnt1",  int'(wr_gnt1), 1);
      pin("e_rdack", int'(rd_ack), 0);
      tick();
      wr_req1 = 0;
      @(negedge clk);
      pin("e_count",  int'(count), 1);
      pin("e_rdack2", int'(rd_ack), 1);
      tick();
      rd_req = 0;
      pin("e_popdata", int'(m_last_pop), 8'h5C);

      // Flush and clear together: clear wins
      wr_req0 = 1;
      for (int i = 0; i < 5; i++) tick();
      wr_req0 = 0; flush_req = 1; clear_req = 1;
      @(negedge clk);
      pin("fc_count5", int'(count), 5);
      tick();
      flush_req = 0; clear_req = 0;
      @(negedge clk);
      pin("fc_clr_n", int'(fifo_clr_n), 0);
      pin("fc_rst_n", int'(fifo_reset_n), 1);
      pin("fc_busy",  int'(busy), 1);
      tick();
      @(negedge clk);
      pin("fc_busy2", int'(busy), 0);
      pin("fc_count", int'(count), 0);
      tick();

      // Reset during FLUSH with count 3; prio left at 1 beforehand
      wr_req0 = 1; wr_req1 = 1;
      tick();
      wr_req1 = 0;
      tick();
      flush_req = 1;
      @(negedge clk);
      pin("fl_gnt0", int'(wr_gnt0), 1);
      tick();
      flush_req = 0; wr_req0 = 0; FIFO_reset = 1;
      @(negedge clk);
      pin("fl_rst_n",  int'(fifo_reset_n), 0);
      pin("fl_count3", int'(count), 3);
      tick();
      FIFO_reset = 0; wr_req0 = 1; wr_req1 = 1; rd_req = 1;
      @(negedge clk);
      pin("rs_clr_n", int'(fifo_clr_n), 0);
      pin("rs_count", int'(count), 0);
      pin("rs_push",  int'(fifo_push), 0);
      pin("rs_pop",   int'(fifo_pop), 0);
      tick();
      @(negedge clk);
      pin("rs_prio_gnt0", int'(wr_gnt0), 1);
      pin("rs_prio_gnt1", int'(wr_gnt1), 0);
      pin("rs_noack",     int'(rd_ack), 0);
      tick();

      // Random traffic checked by the model
      for (int i = 0; i < 400; i++) begin
         wr_req0    = ($urandom_range(99) < 55);
         wr_req1    = ($urandom_range(99) < 55);
         rd_req     = ($urandom_range(99) < 45);
         flush_req  = ($urandom_range(99) < 3);
         clear_req  = ($urandom_range(99) < 3);
         FIFO_reset = ($urandom_range(199) < 1);
         wr_data0   = W'($urandom);
         wr_data1   = W'($urandom);
         tick();
      end
      FIFO_reset = 0; wr_req0 = 0; wr_req1 = 0; rd_req = 0;
      flush_req = 0; clear_req = 0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
